// File: rtl/nibble_add_sequencer.sv
// Sequences one external 4-bit adder across NIBBLES nibbles, LSB first, to form a W-bit sum.
// Define NIBBLE_SEQ_OVF_EN to add the registered two's-complement overflow output ovf.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
`ifdef NIBBLE_SEQ_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_lat;
  logic [W-1:0]  b_lat;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nxt;
  logic [IW+1:0] nib_lo;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign nib_lo = {idx, 2'b00};

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_lat[nib_lo +: 4];
      add_b   = b_lat[nib_lo +: 4];
      add_cin = carry;
    end
  end

  // Merged view lets the final edge load sum including the nibble being produced now.
  always_comb begin
    work_nxt             = work;
    work_nxt[nib_lo +: 4] = add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_lat <= '0;
      b_lat <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef NIBBLE_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            a_lat <= a;
            b_lat <= b;
            carry <= cin;
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= add_cout;
          if (idx == LAST) begin
            state <= DONE;
            idx   <= '0;
            sum   <= work_nxt;
            cout  <= add_cout;
`ifdef NIBBLE_SEQ_OVF_EN
            // The adder hides its MSB-internal carry, so use the operand/result sign rule.
            ovf   <= (a_lat[W-1] == b_lat[W-1]) && (add_sum[3] != a_lat[W-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench for nibble_add_sequencer: a driver queues arithmetic expectations,
// a done-triggered monitor pops and compares them.
module tb_nibble_add_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef NIBBLE_SEQ_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Stand-in for the external Adder4Bit.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_add_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cin(cin), .a(a), .b(b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef NIBBLE_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t            r;
    longint unsigned t;
    longint          sx, sy, s;
    t  = longint'(x) + longint'(y) + longint'(c);
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    s  = sx + sy + longint'(c);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
`ifdef NIBBLE_SEQ_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  // Called at a negedge with busy low; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Issue and follow each nibble on the adder port; ends on the done negedge.
  task automatic run_traced(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    longint unsigned m, c_exp;
    issue(ta, tb_v, tc);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      m     = (longint'(1) << (4*k)) - 1;
      c_exp = ((longint'(ta) & m) + (longint'(tb_v) & m) + longint'(tc)) >> (4*k);
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      check("add_a", add_a, ta[4*k +: 4]);
      check("add_b", add_b, tb_v[4*k +: 4]);
      check("add_cin", add_cin, c_exp[0]);
    end
    @(negedge clk);
    check("busy_done", busy, 1'b0);
    check("done_pulse", done, 1'b1);
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    if (busy) check("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_sum"}, sum, '0);
    check({tag, "_cout"}, cout, 1'b0);
    check({tag, "_add_a"}, add_a, 4'h0);
    check({tag, "_add_b"}, add_b, 4'h0);
    check({tag, "_add_cin"}, add_cin, 1'b0);
`ifdef NIBBLE_SEQ_OVF_EN
    check({tag, "_ovf"}, ovf, 1'b0);
`endif
  endtask

  initial begin
    int d0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with full timing trace.
    run_traced(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    check("done_falls", done, 1'b0);
    check("sum_hold", sum, 16'h5555);

    // Carry ripples through every nibble.
    run_traced(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);

    // Wrap via cin, then back-to-back start from DONE.
    run_traced(16'hFFFF, 16'h0000, 1'b1);
    run_traced(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    check("idle_after_b2b", busy, 1'b0);

    // Restart attempt while busy must be ignored.
    d0 = done_cnt;
    issue(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
    check("ignored_sum", sum, 16'h0100);

    // Reset mid-run discards the addition.
    d0 = done_cnt;
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_stays_idle", busy, 1'b0);

`ifdef NIBBLE_SEQ_OVF_EN
    run_traced(16'h7FFF, 16'h0001, 1'b0);
    run_traced(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
`endif

    // Randomized traffic with mixed gaps and back-to-back starts.
    for (int n = 0; n < 60; n++) begin
      wait_not_busy();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
      @(negedge clk);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
